// File: rtl/drain_pkg.sv
// Shared types and sizing helpers for the result drain sequencer.
package drain_pkg;
    localparam int DEF_RESULT_BIT  = 8;
    localparam int DEF_WRITE_WIDTH = 128;
    localparam int BYTES_PER_WORD  = DEF_WRITE_WIDTH / DEF_RESULT_BIT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } drain_state_t;

    // Packed words produced per pixel; a partial trailing word still costs one write.
    function automatic int unsigned words_per_pixel(input int unsigned out_chan_size,
                                                    input int unsigned bytes_per_word = BYTES_PER_WORD);
        return (out_chan_size + bytes_per_word - 1) / bytes_per_word;
    endfunction
endpackage

// File: rtl/wb_addr_gen.sv
// Output-BRAM write stage: registers packed words, counts writes and
// generates base-relative addresses that wrap with the address width.
module wb_addr_gen #(
    parameter int WRITE_WIDTH = 128,
    parameter int ADDR_BIT    = 12,
    parameter int CNT_BIT     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [ADDR_BIT-1:0]    base_addr,
    input  logic [CNT_BIT-1:0]     target,
    input  logic [WRITE_WIDTH-1:0] word,
    input  logic                   word_valid,
    output logic                   wr_en,
    output logic [ADDR_BIT-1:0]    wr_addr,
    output logic [WRITE_WIDTH-1:0] wr_data,
    output logic                   complete
);
    logic [CNT_BIT-1:0]     wr_cnt_reg, wr_cnt_next;
    logic                   wr_en_reg;
    logic [ADDR_BIT-1:0]    wr_addr_reg;
    logic [WRITE_WIDTH-1:0] wr_data_reg;

    always_comb begin
        wr_cnt_next = wr_cnt_reg;
        if (word_valid) wr_cnt_next = wr_cnt_reg + CNT_BIT'(1);
        if (clear)      wr_cnt_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_reg  <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_cnt_reg <= wr_cnt_next;
            wr_en_reg  <= word_valid;
            if (word_valid) begin
                wr_addr_reg <= base_addr + wr_cnt_reg[ADDR_BIT-1:0];
                wr_data_reg <= word;
            end
        end
    end

    assign wr_en    = wr_en_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign complete = (wr_cnt_reg == target);
endmodule

// File: rtl/result_drain_ctrl.sv
// Serializes PE-row result groups into the byte packer in channel order and
// turns packed words into addressed output-BRAM writes for one layer.
module result_drain_ctrl
    import drain_pkg::*;
#(
    parameter int RESULT_BIT  = DEF_RESULT_BIT,
    parameter int WRITE_WIDTH = DEF_WRITE_WIDTH,
    parameter int NUM_ROWS    = 16,
    parameter int MAX_CHAN    = 256,
    parameter int ADDR_BIT    = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(MAX_CHAN)-1:0]    out_chan_size,
    input  logic [15:0]                    seq_len,
    input  logic [ADDR_BIT-1:0]            base_addr,
    input  logic                           grp_valid,
    input  logic [NUM_ROWS*RESULT_BIT-1:0] grp_data,
    output logic                           grp_ready,
    output logic [RESULT_BIT-1:0]          pack_data,
    output logic                           pack_valid,
    input  logic [WRITE_WIDTH-1:0]         pack_word,
    input  logic                           pack_word_valid,
    output logic                           wr_en,
    output logic [ADDR_BIT-1:0]            wr_addr,
    output logic [WRITE_WIDTH-1:0]         wr_data,
    output logic                           busy,
    output logic                           done
);
    localparam int CHAN_BIT = $clog2(MAX_CHAN);
    localparam int CNT_BIT  = CHAN_BIT + 1;
    localparam int SEL_BIT  = $clog2(NUM_ROWS);
    localparam int N_BIT    = SEL_BIT + 1;

    drain_state_t                   state_reg, state_next;
    logic [NUM_ROWS*RESULT_BIT-1:0] grp_reg, grp_next;
    logic [N_BIT-1:0]               n_reg, n_next;
    logic [SEL_BIT-1:0]             idx_reg, idx_next;
    logic [CNT_BIT-1:0]             chan_cnt_reg, chan_cnt_next;
    logic [CHAN_BIT-1:0]            ocs_reg, ocs_next;
    logic [15:0]                    pix_cnt_reg, pix_cnt_next, seq_reg, seq_next;
    logic [ADDR_BIT-1:0]            base_reg, base_next;
    logic [31:0]                    target_reg, target_next;
    logic                           done_reg, done_next, busy_reg, busy_next;
    logic                           wb_clear, wb_complete;
    logic [CNT_BIT-1:0]             remaining, chan_sum;
    logic [RESULT_BIT-1:0]          grp_bytes [NUM_ROWS];

    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_bytes
        assign grp_bytes[gi] = grp_reg[gi*RESULT_BIT +: RESULT_BIT];
    end

    assign remaining = {1'b0, ocs_reg} - chan_cnt_reg;
    assign chan_sum  = chan_cnt_reg + CNT_BIT'(n_reg);

    always_comb begin
        state_next    = state_reg;
        grp_next      = grp_reg;
        n_next        = n_reg;
        idx_next      = idx_reg;
        chan_cnt_next = chan_cnt_reg;
        pix_cnt_next  = pix_cnt_reg;
        ocs_next      = ocs_reg;
        seq_next      = seq_reg;
        base_next     = base_reg;
        target_next   = target_reg;
        done_next     = 1'b0;
        busy_next     = busy_reg;
        wb_clear      = 1'b0;
        grp_ready     = 1'b0;
        pack_valid    = 1'b0;
        pack_data     = '0;
        case (state_reg)
            IDLE: if (start) begin
                ocs_next      = out_chan_size;
                seq_next      = seq_len;
                base_next     = base_addr;
                target_next   = 32'(seq_len) * words_per_pixel(32'(out_chan_size), WRITE_WIDTH / RESULT_BIT);
                chan_cnt_next = '0;
                pix_cnt_next  = '0;
                wb_clear      = 1'b1;
                if (seq_len == 16'd0) begin
                    done_next = 1'b1;
                end else begin
                    state_next = LOAD;
                    busy_next  = 1'b1;
                end
            end
            LOAD: begin
                grp_ready = 1'b1;
                if (grp_valid) begin
                    grp_next   = grp_data;
                    n_next     = (remaining > CNT_BIT'(NUM_ROWS)) ? N_BIT'(NUM_ROWS) : N_BIT'(remaining);
                    idx_next   = '0;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                pack_valid = 1'b1;
                pack_data  = grp_bytes[idx_reg];
                if ({1'b0, idx_reg} == n_reg - N_BIT'(1)) begin
                    // Trailing bytes of a partial group are simply never selected.
                    if (chan_sum == {1'b0, ocs_reg}) begin
                        chan_cnt_next = '0;
                        pix_cnt_next  = pix_cnt_reg + 16'd1;
                        state_next    = (pix_cnt_reg + 16'd1 == seq_reg) ? FLUSH : LOAD;
                    end else begin
                        chan_cnt_next = chan_sum;
                        state_next    = LOAD;
                    end
                end else begin
                    idx_next = idx_reg + SEL_BIT'(1);
                end
            end
            FLUSH: if (wb_complete) begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            grp_reg      <= '0;
            n_reg        <= '0;
            idx_reg      <= '0;
            chan_cnt_reg <= '0;
            pix_cnt_reg  <= '0;
            ocs_reg      <= '0;
            seq_reg      <= '0;
            base_reg     <= '0;
            target_reg   <= '0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grp_reg      <= grp_next;
            n_reg        <= n_next;
            idx_reg      <= idx_next;
            chan_cnt_reg <= chan_cnt_next;
            pix_cnt_reg  <= pix_cnt_next;
            ocs_reg      <= ocs_next;
            seq_reg      <= seq_next;
            base_reg     <= base_next;
            target_reg   <= target_next;
            done_reg     <= done_next;
            busy_reg     <= busy_next;
        end
    end

    assign done = done_reg;
    assign busy = busy_reg;

    wb_addr_gen #(
        .WRITE_WIDTH(WRITE_WIDTH),
        .ADDR_BIT   (ADDR_BIT),
        .CNT_BIT    (32)
    ) u_wb_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (wb_clear),
        .base_addr (base_reg),
        .target    (target_reg),
        .word      (pack_word),
        .word_valid(pack_word_valid),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .complete  (wb_complete)
    );
endmodule

// File: doc/result_drain_ctrl.md
# result_drain_ctrl

Sequencer between the PE-row result outputs and the byte-to-word packing accumulator. It accepts one group of NUM_ROWS per-row results at a time, serializes them one byte per cycle into the accumulator in output-channel order, and turns the accumulator's packed words into addressed output-BRAM writes. It counts channels and pixels for one layer, then pulses `done`.

## Interface
- RESULT_BIT, 8, width of one quantized result byte
- WRITE_WIDTH, 128, packed word / BRAM write width
- NUM_ROWS, 16, results per input group (one per PE row)
- MAX_CHAN, 256, bound on out_chan_size
- ADDR_BIT, 12, output BRAM address width

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; latches config, begins layer
- out_chan_size  in  $clog2(MAX_CHAN)  output channels per pixel, 1..MAX_CHAN-1
- seq_len  in  16  pixels in layer
- base_addr  in  ADDR_BIT  BRAM address of first word
- grp_valid  in  1  result group present
- grp_data  in  NUM_ROWS*RESULT_BIT  group; byte k at [k*RESULT_BIT +: RESULT_BIT]
- grp_ready  out  1  group accepted when grp_valid && grp_ready
- pack_data  out  RESULT_BIT  to accumulator in_data
- pack_valid  out  1  to accumulator valid_i
- pack_word  in  WRITE_WIDTH  from accumulator out
- pack_word_valid  in  1  from accumulator valid_o
- wr_en, wr_addr, wr_data  out  1 / ADDR_BIT / WRITE_WIDTH  BRAM write port
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at layer end

## Operation
- States: IDLE, LOAD, DRAIN, FLUSH.
- IDLE: `start` latches out_chan_size, seq_len and base_addr, clears the counters, then goes to LOAD. If seq_len==0, the block instead pulses `done` the next cycle and stays in IDLE.
- LOAD: `grp_ready`=1. A handshake captures grp_data and sets n = min(NUM_ROWS, out_chan_size - chan_cnt). Next state is DRAIN.
- DRAIN: emits bytes 0..n-1, one per cycle, with pack_valid=1. After byte n-1, chan_cnt advances by n.
  - If chan_cnt reaches out_chan_size: chan_cnt←0, pix_cnt++.
  - Next state is LOAD, or FLUSH if the last pixel has been completed.
  - Bytes n..NUM_ROWS-1 of a partial group are discarded.
- FLUSH: waits until wr_cnt == seq_len * ceil(out_chan_size*RESULT_BIT/WRITE_WIDTH). Then it pulses `done` and returns to IDLE.
- Write path, in every state:
  - A cycle with pack_word_valid registers wr_en=1, wr_data=pack_word and wr_addr=base_addr+wr_cnt, then wr_cnt++.
  - wr_addr wraps modulo 2^ADDR_BIT.
- `start` is ignored while busy.
- Holding grp_valid low in LOAD stalls the block indefinitely. pack_valid stays 0 while stalled.
- The accumulator's internal counters are only cleared by reset. `rst` must therefore also reset the accumulator (system ties its rst_n = !rst).

## Timing
- Reset values: grp_ready=0, pack_valid=0, pack_data=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, state=IDLE.
- start at cycle T → LOAD and busy=1 at T+1.
- Group accepted at T → pack_valid at T+1..T+n, LOAD again at T+n+1. Sustained rate is n bytes per n+1 cycles.
- pack_word_valid at T → wr_en at T+1 (registered, 1-cycle latency).
- done is asserted in the cycle after the final wr_en. busy falls in the same cycle.
- Reset mid-operation → all outputs to their reset values on the next edge. Partially packed data is lost, and no write is issued for it.

## Structure
- Package `drain_pkg` holds:
  - the state enum typedef;
  - a localparam BYTES_PER_WORD = WRITE_WIDTH/RESULT_BIT;
  - a function `words_per_pixel(out_chan_size)` returning the ceil division.
- Sub-module `wb_addr_gen` holds the write-path register stage, wr_cnt, base-relative address and completion compare.
- The FSM, group capture register and byte mux stay in the top module.

## Test plan
- out_chan_size=16, seq_len=2, groups of bytes 0x00..0x0F:
  - 16+16 pack_valid bytes in order;
  - two writes at base, base+1, each wr_data=0x000102..0F;
  - done once.
- out_chan_size=20, seq_len=1, base=0x10:
  - group1 drains 16 bytes, group2 drains 4 (bytes 4..15 dropped);
  - writes at 0x10 and 0x11, second word low 32 bits = group2 bytes 0..3;
  - done.
- grp_valid held low for 5 cycles in LOAD → pack_valid=0 throughout, no spurious writes; resuming completes normally.
- seq_len=0 start → done the next cycle, zero writes; start pulsed while busy → ignored, counts unchanged.
- base_addr=0xFFF, 2 words → wr_addr 0xFFF then 0x000.
- rst asserted mid-DRAIN → next cycle all outputs at reset values; a fresh start then completes a full layer correctly.
